regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single 64-bit register-file write port between NUM_REQ writeback sources
//  (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake.
//  Registers the winning write into the RF write port. Keeps a 32-entry pending-write
//  scoreboard that decode queries to stall on RAW hazards. Sits between execute/memory
//  stages and the register file.
// PARAMETERS
//  NUM_REQ    3   number of writeback requesters (2..8)
//  XLEN       64  data width
//  NUM_REGS   32  architectural registers (address width fixed at 5)
// PORTS
//  CLOCK          in   1              system clock, rising edge
//  RESET_N        in   1              asynchronous, active-low reset
//  WB_VALID       in   NUM_REQ        requester i has a write pending
//  WB_ADDR        in   NUM_REQ*5      rd of requester i, slice [i*5+:5]
//  WB_DATA        in   NUM_REQ*XLEN   data of requester i, slice [i*XLEN+:XLEN]
//  WB_READY       out  NUM_REQ        one-hot grant; transfer = VALID[i] & READY[i]
//  RF_WE          out  1              to register-file WRITE_ENABLE
//  RF_WADDR       out  5              to register-file WRITE_ADDRESS
//  RF_WDATA       out  XLEN           to register-file WRITE_DATA
//  ISSUE_VALID    in   1              decode issues an instruction writing ISSUE_RD
//  ISSUE_RD       in   5              destination register of issued instruction
//  FLUSH          in   1              pipeline flush: clear scoreboard
//  RS1, RS2       in   5 each         source registers queried by decode
//  STALL          out  1              PENDING[RS1] | PENDING[RS2] (combinational)
//  PENDING        out  NUM_REGS       scoreboard bit per register
// BEHAVIOUR
//  Reset (RESET_N=0, async): RF_WE=0, RF_WADDR=0, RF_WDATA=0, PENDING=0, rr pointer=0.
//   WB_READY and STALL then follow the reset state combinationally.
//  Arbitration (combinational):
//   - Search WB_VALID starting at the pointer and wrap modulo NUM_REQ.
//   - The first valid requester gets WB_READY=1; every other WB_READY is 0.
//   - No valid requester: WB_READY=0.
//   - WB_READY never depends on its own WB_VALID beyond selection, so there are no
//     comb loops.
//  Pointer: after a transfer by requester g, pointer <= (g+1) mod NUM_REQ. Otherwise hold.
//  Write port:
//   - Transfer in cycle t -> RF_WE=1, RF_WADDR/RF_WDATA = granted ADDR/DATA in cycle
//     t+1, for exactly one cycle.
//   - No transfer -> RF_WE=0. Address and data hold their last values.
//   - Fixed latency of 1 cycle. One write per cycle. The port never back-pressures.
//  x0: a transfer with ADDR=0 is granted and consumed (READY=1), but RF_WE stays 0 and
//   the scoreboard is untouched.
//  Scoreboard (all updates on the rising edge):
//   - ISSUE_VALID with ISSUE_RD!=0 sets PENDING[ISSUE_RD].
//   - A transfer with ADDR!=0 clears PENDING[ADDR] (cleared at the same edge that
//     loads RF_WE).
//   - Set and clear of the same register in one cycle: set wins, because the newer
//     instruction is in flight.
//   - PENDING[0] is hard-wired to 0.
//  FLUSH: clears all PENDING bits at the edge, and FLUSH beats a simultaneous ISSUE.
//   A transfer in the FLUSH cycle still produces its RF write in the next cycle.
//  STALL is computed from the registered PENDING only. A register cleared this cycle
//   stalls until the next edge; the RF write becomes visible on that same edge.
//  Requester rule: once VALID is high it holds, with stable ADDR/DATA, until READY. The
//   arbiter does not check this.
//  Reset mid-operation: an in-flight RF_WE is dropped immediately and the scoreboard
//   is cleared.
// TESTING
//  1. Reset: hold RESET_N=0 with WB_VALID=3'b111 -> RF_WE=0, PENDING=0, WB_READY=3'b001
//     (pointer 0).
//  2. Round-robin: WB_VALID=3'b111 held for 4 cycles -> grants 0,1,2,0. RF_WE high from
//     cycle 2 on, with RF_WADDR following each granted ADDR one cycle later.
//  3. Latency/data: only req1 valid, ADDR=5, DATA=64'hDEAD_BEEF_0123_4567 -> READY[1]=1
//     in cycle t. RF_WE=1, RF_WADDR=5, data matches in t+1. RF_WE=0 in t+2.
//  4. x0 discard: req0 ADDR=0, DATA=64'hFFFF... -> READY[0]=1, RF_WE stays 0,
//     PENDING unchanged.
//  5. Scoreboard: issue rd=7 -> PENDING[7]=1, and RS1=7 gives STALL=1. Req2 writes
//     rd=7 -> PENDING[7]=0 at the next edge and STALL=0. Issue rd=7 and write rd=7 in
//     the same cycle -> PENDING[7] stays 1.
//  6. FLUSH with PENDING=32'h0000_00F0 and a concurrent transfer to rd=4 -> PENDING=0
//     and the RF write to x4 still occurs. Assert RESET_N=0 while RF_WE=1 -> RF_WE
//     drops immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// plus the pending-write scoreboard that decode uses to stall on RAW hazards.
//
// Ports:
//   CLOCK, RESET_N        clock, asynchronous active-low reset
//   WB_VALID/ADDR/DATA    per-requester write requests (packed slices)
//   WB_READY              one-hot grant; transfer = VALID & READY
//   RF_WE/WADDR/WDATA     registered write to the register file
//   ISSUE_VALID/ISSUE_RD  decode marks a destination register as in flight
//   FLUSH                 clears the scoreboard
//   RS1/RS2, STALL        decode hazard query on the registered scoreboard
//   PENDING               scoreboard bit per register
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                    CLOCK,
  input  logic                    RESET_N,
  input  logic [NUM_REQ-1:0]      WB_VALID,
  input  logic [NUM_REQ*5-1:0]    WB_ADDR,
  input  logic [NUM_REQ*XLEN-1:0] WB_DATA,
  output logic [NUM_REQ-1:0]      WB_READY,
  output logic                    RF_WE,
  output logic [4:0]              RF_WADDR,
  output logic [XLEN-1:0]         RF_WDATA,
  input  logic                    ISSUE_VALID,
  input  logic [4:0]              ISSUE_RD,
  input  logic                    FLUSH,
  input  logic [4:0]              RS1,
  input  logic [4:0]              RS2,
  output logic                    STALL,
  output logic [NUM_REGS-1:0]     PENDING
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic                xfer;
  int                  gnt_idx;
  int                  idx;
  int                  nxt;
  logic [4:0]          gnt_addr;
  logic [XLEN-1:0]     gnt_data;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    WB_READY = '0;
    xfer     = 1'b0;
    gnt_idx  = 0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!xfer && WB_VALID[idx]) begin
        xfer          = 1'b1;
        WB_READY[idx] = 1'b1;
        gnt_idx       = idx;
      end
    end
  end

  assign gnt_addr = WB_ADDR[gnt_idx*5 +: 5];
  assign gnt_data = WB_DATA[gnt_idx*XLEN +: XLEN];

  always_comb begin
    nxt   = gnt_idx + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_d = xfer ? PTR_W'(nxt) : ptr_q;
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    we_d    = xfer && (gnt_addr != 5'd0);
    waddr_d = we_d ? gnt_addr : waddr_q;
    wdata_d = we_d ? gnt_data : wdata_q;
  end

  // Clear, then set (newer issue wins), then flush overrides both.
  always_comb begin
    pend_d = pend_q;
    if (we_d) pend_d[gnt_addr] = 1'b0;
    if (ISSUE_VALID && ISSUE_RD != 5'd0) pend_d[ISSUE_RD] = 1'b1;
    if (FLUSH) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign RF_WE    = we_q;
  assign RF_WADDR = waddr_q;
  assign RF_WDATA = wdata_q;
  assign PENDING  = pend_q;
  assign STALL    = pend_q[RS1] | pend_q[RS2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus random bench for regfile_wb_arbiter against a behavioural
// model of the grant order, write port and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int N = 3;
  localparam int XL = 64;

  logic            CLOCK = 1'b0;
  logic            RESET_N;
  logic [N-1:0]    WB_VALID;
  logic [N*5-1:0]  WB_ADDR;
  logic [N*XL-1:0] WB_DATA;
  logic [N-1:0]    WB_READY;
  logic            RF_WE;
  logic [4:0]      RF_WADDR;
  logic [XL-1:0]   RF_WDATA;
  logic            ISSUE_VALID;
  logic [4:0]      ISSUE_RD;
  logic            FLUSH;
  logic [4:0]      RS1, RS2;
  logic            STALL;
  logic [31:0]     PENDING;

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .NUM_REGS(32)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .WB_READY(WB_READY),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .FLUSH(FLUSH),
    .RS1(RS1), .RS2(RS2), .STALL(STALL), .PENDING(PENDING)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad = 0;

  logic [N-1:0]  r_valid;
  logic [4:0]    r_addr [N];
  logic [XL-1:0] r_data [N];

  int          m_ptr;
  int          m_g;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [XL-1:0] m_wdata;

  task automatic chk(input string tag, input logic [XL-1:0] obs,
                     input logic [XL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_pend  = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic drive();
    WB_VALID = r_valid;
    for (int i = 0; i < N; i++) begin
      WB_ADDR[i*5 +: 5]  = r_addr[i];
      WB_DATA[i*XL +: XL] = r_data[i];
    end
  endtask

  // One clock: check comb outputs, step the model, check registered outputs.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    m_g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_g < 0 && r_valid[j]) m_g = j;
    end
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    chk("ready", XL'(WB_READY), XL'(exp_rdy));
    chk("stall", XL'(STALL), XL'(m_pend[RS1] | m_pend[RS2]));
    @(posedge CLOCK);
    m_we = 1'b0;
    if (m_g >= 0) begin
      m_ptr = (m_g + 1) % N;
      if (r_addr[m_g] != 0) begin
        m_we    = 1'b1;
        m_waddr = r_addr[m_g];
        m_wdata = r_data[m_g];
        m_pend[r_addr[m_g]] = 1'b0;
      end
    end
    if (ISSUE_VALID && ISSUE_RD != 0) m_pend[ISSUE_RD] = 1'b1;
    if (FLUSH) m_pend = '0;
    #1;
    chk("rf_we", XL'(RF_WE), XL'(m_we));
    chk("pending", XL'(PENDING), XL'(m_pend));
    if (m_we) begin
      chk("rf_waddr", XL'(RF_WADDR), XL'(m_waddr));
      chk("rf_wdata", RF_WDATA, m_wdata);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    ISSUE_VALID = 1'b0; ISSUE_RD = '0; FLUSH = 1'b0;
    RS1 = '0; RS2 = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 5'(i + 1);
      r_data[i] = 64'h1111_0000_0000_0000 * (i + 1);
    end
    r_valid = 3'b111;
    drive();
    model_reset();

    // Reset state with all requesters valid.
    #12;
    chk("rst_ready", XL'(WB_READY), XL'(3'b001));
    chk("rst_we", XL'(RF_WE), 0);
    chk("rst_pend", XL'(PENDING), 0);
    chk("rst_waddr", XL'(RF_WADDR), 0);
    chk("rst_wdata", RF_WDATA, 0);
    RESET_N = 1'b1;

    // Round robin 0,1,2,0.
    for (int c = 0; c < 4; c++) cycle();

    // Single request latency and data.
    r_valid = 3'b010; r_addr[1] = 5'd5; r_data[1] = 64'hDEAD_BEEF_0123_4567;
    cycle();
    chk("lat_waddr", XL'(RF_WADDR), 5);
    chk("lat_wdata", RF_WDATA, 64'hDEAD_BEEF_0123_4567);
    r_valid = '0;
    cycle();

    // x0 discard.
    r_valid = 3'b001; r_addr[0] = 5'd0; r_data[0] = '1;
    cycle();
    r_valid = '0;

    // Scoreboard set, clear, and set-beats-clear.
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
    cycle();
    ISSUE_VALID = 1'b0; RS1 = 5'd7;
    r_valid = 3'b100; r_addr[2] = 5'd7; r_data[2] = 64'h77;
    cycle();
    r_valid = '0;
    cycle();
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
    r_valid = 3'b100; r_data[2] = 64'h78;
    cycle();
    chk("set_wins", XL'(PENDING[7]), 1);
    r_valid = '0; ISSUE_VALID = 1'b0;

    // Build PENDING = 0xF0 then flush with concurrent x4 write.
    for (int r = 4; r < 8; r++) begin
      ISSUE_VALID = 1'b1; ISSUE_RD = 5'(r);
      cycle();
    end
    chk("pend_f0", XL'(PENDING), 64'hF0);
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9; FLUSH = 1'b1;
    r_valid = 3'b001; r_addr[0] = 5'd4; r_data[0] = 64'h4444;
    cycle();
    chk("flush_waddr", XL'(RF_WADDR), 4);
    ISSUE_VALID = 1'b0; FLUSH = 1'b0; r_valid = '0;

    // Async reset while a write is in flight.
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd3;
    r_valid = 3'b010; r_addr[1] = 5'd12; r_data[1] = 64'hC;
    cycle();
    chk("pre_rst_we", XL'(RF_WE), 1);
    ISSUE_VALID = 1'b0; r_valid = '0; drive();
    RESET_N = 1'b0;
    #1;
    chk("midrst_we", XL'(RF_WE), 0);
    chk("midrst_pend", XL'(PENDING), 0);
    model_reset();
    #2;
    RESET_N = 1'b1;

    // Random traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i] || m_g == i) begin
          r_valid[i] = ($urandom_range(0, 2) != 0);
          r_addr[i]  = 5'($urandom_range(0, 31));
          r_data[i]  = {$urandom(), $urandom()};
        end
      end
      ISSUE_VALID = $urandom_range(0, 1) == 1;
      ISSUE_RD    = 5'($urandom_range(0, 31));
      FLUSH       = $urandom_range(0, 19) == 0;
      RS1         = 5'($urandom_range(0, 31));
      RS2         = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
